// File: rtl/acc_core_pkg.sv
// Shared opcode and FSM encodings for the sequential accumulator core.
package acc_core_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_LDR = 4'd6;
  localparam logic [3:0] OP_STR = 4'd7;
  localparam logic [3:0] OP_IN  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd9;
  localparam logic [3:0] OP_SUB = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Per-op write enables decoded by the single-cycle ALU.
  typedef struct packed {
    logic wr_acc;
    logic wr_carry;
    logic carry;
  } alu_ctl_t;

endpackage

// File: rtl/acc_core_seq_mul.sv
// Shift-add multiplier: one multiplier bit per cycle, LSB first.
// product is the running sum including the current step, so on the cycle
// done is high it already holds the final result.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               running;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] psum;
  logic [WIDTH-1:0]   mplier;

  assign product = psum + (mplier[0] ? mcand : '0);
  assign done    = running && (cnt == CW'(WIDTH - 1));

  // Operand latch on start, then one shift-add step per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      psum    <= '0;
      mplier  <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      mcand   <= {{WIDTH{1'b0}}, a};
      psum    <= '0;
      mplier  <= b;
    end else if (running) begin
      psum    <= product;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      cnt     <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/acc_core_seq.sv
// Clocked accumulator core: ALU ops between acc and a small register file,
// valid/ready instruction intake, multi-cycle multiply.
module acc_core_seq
  import acc_core_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 4,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [RW-1:0]    instr_reg,
  input  logic [WIDTH-1:0] instr_imm,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             zero_flag,
  output logic             carry_flag
);

  state_e                       state;
  logic [WIDTH-1:0]             acc;
  logic [NREGS-1:0][WIDTH-1:0]  regs;
  logic                         accept;
  logic [WIDTH-1:0]             r_val;
  logic [WIDTH-1:0]             acc_nxt;
  logic [WIDTH:0]               sum;
  alu_ctl_t                     ctl;
  logic                         mul_start;
  logic                         mul_done;
  logic [2*WIDTH-1:0]           mul_prod;

  assign instr_ready = (state == ST_IDLE) && !reset;
  assign busy        = (state == ST_MUL);
  assign accept      = instr_valid && instr_ready;
  assign r_val       = regs[instr_reg];
  assign acc_out     = acc;
  assign sum         = {1'b0, acc} + {1'b0, r_val};
  assign mul_start   = accept && (instr_op == OP_MUL);

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (acc),
    .b       (r_val),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Single-cycle ALU: next acc value and which flags it touches.
  always_comb begin
    acc_nxt = acc;
    ctl     = '{wr_acc: 1'b0, wr_carry: 1'b0, carry: carry_flag};
    unique case (instr_op)
      OP_ADD: begin {ctl.carry, acc_nxt} = sum; ctl.wr_acc = 1'b1; ctl.wr_carry = 1'b1; end
      OP_AND: begin acc_nxt = acc & r_val;  ctl.wr_acc = 1'b1; end
      OP_OR:  begin acc_nxt = acc | r_val;  ctl.wr_acc = 1'b1; end
      OP_NOT: begin acc_nxt = ~acc;         ctl.wr_acc = 1'b1; end
      OP_LDI: begin acc_nxt = instr_imm;    ctl.wr_acc = 1'b1; end
      OP_LDR: begin acc_nxt = r_val;        ctl.wr_acc = 1'b1; end
      OP_IN:  begin acc_nxt = in_data;      ctl.wr_acc = 1'b1; end
      OP_SUB: begin
        acc_nxt      = acc - r_val;
        ctl.carry    = (acc < r_val);
        ctl.wr_acc   = 1'b1;
        ctl.wr_carry = 1'b1;
      end
      default: ;  // MUL finishes in ST_MUL; STR/OUT/NOPs leave acc alone
    endcase
  end

  // Control FSM plus all architectural state (acc, regs, flags, output port).
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      acc        <= '0;
      regs       <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        ST_IDLE: if (accept) begin
          if (ctl.wr_acc) begin
            acc       <= acc_nxt;
            zero_flag <= (acc_nxt == '0);
          end
          if (ctl.wr_carry) carry_flag <= ctl.carry;
          if (instr_op == OP_STR) regs[instr_reg] <= acc;
          if (instr_op == OP_OUT) begin
            out_data  <= acc;
            out_valid <= 1'b1;
          end
          if (instr_op == OP_MUL) state <= ST_MUL;
        end
        ST_MUL: if (mul_done) begin
          acc        <= mul_prod[WIDTH-1:0];
          zero_flag  <= (mul_prod[WIDTH-1:0] == '0);
          carry_flag <= |mul_prod[2*WIDTH-1:WIDTH];
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_core_seq.sv
// Scoreboard bench for acc_core_seq: the driver queues the expected
// architectural state per instruction, the monitor checks it after each accept.
module tb_acc_core_seq;

  localparam int WIDTH = 8;
  localparam int NREGS = 4;
  localparam int RW    = 2;

  localparam logic [3:0] ADD = 4'd0, MUL = 4'd1, AND_ = 4'd2, OR_ = 4'd3,
                         NOT_ = 4'd4, LDI = 4'd5, LDR = 4'd6, STR = 4'd7,
                         IN_ = 4'd8, OUT = 4'd9, SUB = 4'd10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             instr_valid = 1'b0;
  logic             instr_ready;
  logic [3:0]       instr_op = '0;
  logic [RW-1:0]    instr_reg = '0;
  logic [WIDTH-1:0] instr_imm = '0;
  logic [WIDTH-1:0] in_data = '0;
  logic [WIDTH-1:0] acc_out;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             busy;
  logic             zero_flag;
  logic             carry_flag;

  acc_core_seq #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_reg   (instr_reg),
    .instr_imm   (instr_imm),
    .in_data     (in_data),
    .acc_out     (acc_out),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .busy        (busy),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] acc;
    logic       z;
    logic       c;
    logic [7:0] od;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_iss = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Queue the expected post-op state, then present the instruction until accepted.
  task automatic issue(input logic [3:0] op, input int r, input logic [7:0] imm,
                       input logic [7:0] ea, input logic ez, input logic ec,
                       input logic [7:0] eo, input logic eov, input bit rnd);
    exp_t e;
    e = '{id: n_iss, acc: ea, z: ez, c: ec, od: eo, ov: eov};
    sb.push_back(e);
    n_iss++;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      instr_op    = op;
      instr_reg   = RW'(r);
      instr_imm   = imm;
      instr_valid = (rnd && t < 6) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      if (instr_valid && instr_ready) break;
      if (t > 60) begin
        chk("accept_timeout", 16'(instr_ready), 16'h1);
        break;
      end
    end
    #1 instr_valid = 1'b0;
  endtask

  // Monitor: after each accept, wait out any multiply, then compare.
  exp_t m_e;
  int   m_w;
  initial begin
    forever begin
      @(posedge clk);
      if (!reset && instr_valid && instr_ready) begin
        m_w = 0;
        @(negedge clk);
        while (busy && m_w < 40) begin
          @(negedge clk);
          m_w++;
        end
        if (busy) chk("mul_done_timeout", 16'(busy), 16'h0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_accept: got op %0d with empty queue, expected none", instr_op);
        end else begin
          m_e = sb.pop_front();
          chk($sformatf("acc#%0d", m_e.id),       16'(acc_out),    16'(m_e.acc));
          chk($sformatf("zero#%0d", m_e.id),      16'(zero_flag),  16'(m_e.z));
          chk($sformatf("carry#%0d", m_e.id),     16'(carry_flag), 16'(m_e.c));
          chk($sformatf("out_data#%0d", m_e.id),  16'(out_data),   16'(m_e.od));
          chk($sformatf("out_valid#%0d", m_e.id), 16'(out_valid),  16'(m_e.ov));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  int cnt;
  initial begin
    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    chk("ready_in_reset", 16'(instr_ready), 16'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_acc",   16'(acc_out),    16'h0);
    chk("rst_zero",  16'(zero_flag),  16'h0);
    chk("rst_carry", 16'(carry_flag), 16'h0);
    chk("rst_ov",    16'(out_valid),  16'h0);
    chk("rst_od",    16'(out_data),   16'h0);
    chk("rst_busy",  16'(busy),       16'h0);
    chk("rst_ready", 16'(instr_ready), 16'h1);

    // ADD carry-out and SUB borrow
    issue(LDI, 0, 8'hF0, 8'hF0, 0, 0, 8'h00, 0, 0);
    issue(STR, 1, 8'h00, 8'hF0, 0, 0, 8'h00, 0, 0);
    issue(LDI, 0, 8'h20, 8'h20, 0, 0, 8'h00, 0, 0);
    issue(ADD, 1, 8'h00, 8'h10, 0, 1, 8'h00, 0, 0);
    issue(SUB, 1, 8'h00, 8'h20, 0, 1, 8'h00, 0, 0);

    // Multiply: latency and overflow
    issue(LDI, 0, 8'h03, 8'h03, 0, 1, 8'h00, 0, 0);
    issue(STR, 2, 8'h00, 8'h03, 0, 1, 8'h00, 0, 0);
    issue(LDI, 0, 8'h05, 8'h05, 0, 1, 8'h00, 0, 0);
    issue(MUL, 2, 8'h00, 8'h0F, 0, 0, 8'h00, 0, 0);
    cnt = 0;
    @(negedge clk);
    while (!instr_ready && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("mul_ready_low_cycles", 16'(cnt), 16'd8);
    issue(LDI, 0, 8'h20, 8'h20, 0, 0, 8'h00, 0, 0);
    issue(STR, 3, 8'h00, 8'h20, 0, 0, 8'h00, 0, 0);
    issue(LDI, 0, 8'h10, 8'h10, 0, 0, 8'h00, 0, 0);
    issue(MUL, 3, 8'h00, 8'h00, 1, 1, 8'h00, 0, 0);

    // IN / NOT / OUT pulses, AND with zero reg, STR->LDR/ADD forwarding, acc^2
    in_data = 8'h5A;
    issue(IN_,  0, 8'h00, 8'h5A, 0, 1, 8'h00, 0, 0);
    issue(NOT_, 0, 8'h00, 8'hA5, 0, 1, 8'h00, 0, 0);
    issue(OUT,  0, 8'h00, 8'hA5, 0, 1, 8'hA5, 1, 0);
    issue(OUT,  0, 8'h00, 8'hA5, 0, 1, 8'hA5, 1, 0);
    issue(AND_, 0, 8'h00, 8'h00, 1, 1, 8'hA5, 0, 0);
    issue(LDI,  0, 8'h33, 8'h33, 0, 1, 8'hA5, 0, 0);
    issue(STR,  0, 8'h00, 8'h33, 0, 1, 8'hA5, 0, 0);
    issue(LDR,  0, 8'h00, 8'h33, 0, 1, 8'hA5, 0, 0);
    issue(ADD,  0, 8'h00, 8'h66, 0, 0, 8'hA5, 0, 0);
    issue(STR,  1, 8'h00, 8'h66, 0, 0, 8'hA5, 0, 0);
    issue(MUL,  1, 8'h00, 8'hA4, 0, 1, 8'hA5, 0, 0);
    issue(OR_,  2, 8'h00, 8'hA7, 0, 1, 8'hA5, 0, 0);

    // Reset in the 4th MUL cycle aborts it: everything returns to zero
    issue(MUL, 2, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 16'(busy),    16'h0);
    chk("abort_acc",  16'(acc_out), 16'h0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_stale_acc",   16'(acc_out),    16'h0);
    chk("abort_no_stale_carry", 16'(carry_flag), 16'h0);
    chk("abort_idle_ready",     16'(instr_ready), 16'h1);

    // Stream with randomly toggling instr_valid
    in_data = 8'hC3;
    issue(LDI,   0, 8'h01, 8'h01, 0, 0, 8'h00, 0, 1);
    issue(STR,   1, 8'h00, 8'h01, 0, 0, 8'h00, 0, 1);
    issue(ADD,   1, 8'h00, 8'h02, 0, 0, 8'h00, 0, 1);
    issue(4'd11, 1, 8'h77, 8'h02, 0, 0, 8'h00, 0, 1);
    issue(OUT,   0, 8'h00, 8'h02, 0, 0, 8'h02, 1, 1);
    issue(LDI,   0, 8'hFF, 8'hFF, 0, 0, 8'h02, 0, 1);
    issue(ADD,   1, 8'h00, 8'h00, 1, 1, 8'h02, 0, 1);
    issue(4'd15, 2, 8'h55, 8'h00, 1, 1, 8'h02, 0, 1);
    issue(OUT,   0, 8'h00, 8'h00, 1, 1, 8'h00, 1, 1);
    issue(SUB,   1, 8'h00, 8'hFF, 0, 1, 8'h00, 0, 1);
    issue(4'd12, 3, 8'h00, 8'hFF, 0, 1, 8'h00, 0, 1);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
